// File: rtl/median_window_scan_ctrl_if.sv
// rtl/median_window_scan_ctrl_if.sv - control/status bundle between scan controller and its neighbours
// Purpose: groups the start/stop/stall controls and the window strobe/coordinate outputs.
// Ports (signals):
//   i_start, i_stop, i_stall      : controls driven by the master (BRAM read sequencer side)
//   o_state, o_enable_win         : controller state and per-cycle window strobe
//   o_col, o_row                  : window coordinates (CW / RW bits)
//   o_first_col, o_row_end,
//   o_frame_end, o_busy           : row/frame markers and activity flag
//   o_frame_cnt                   : completed-frame counter (CNT_W bits)
interface median_window_scan_ctrl_if #(
    parameter int CW    = 3,
    parameter int RW    = 3,
    parameter int CNT_W = 8
);
    logic             i_start;
    logic             i_stop;
    logic             i_stall;
    logic [2:0]       o_state;
    logic             o_enable_win;
    logic [CW-1:0]    o_col;
    logic [RW-1:0]    o_row;
    logic             o_first_col;
    logic             o_row_end;
    logic             o_frame_end;
    logic             o_busy;
    logic [CNT_W-1:0] o_frame_cnt;

    modport master (
        output i_start, i_stop, i_stall,
        input  o_state, o_enable_win, o_col, o_row, o_first_col,
               o_row_end, o_frame_end, o_busy, o_frame_cnt
    );

    modport slave (
        input  i_start, i_stop, i_stall,
        output o_state, o_enable_win, o_col, o_row, o_first_col,
               o_row_end, o_frame_end, o_busy, o_frame_cnt
    );
endinterface

// File: rtl/median_window_scan_ctrl.sv
// rtl/median_window_scan_ctrl.sv - window-scan controller producing enable strobe and coordinates for a WIN x WIN median engine
// Purpose: walks an OUT_W x OUT_H grid of window positions with an initial delay,
//          inter-row gaps and an inter-frame gap; supports stall, abort and auto restart.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : median_window_scan_ctrl_if.slave (controls in, strobe/coordinates/markers out)
module median_window_scan_ctrl #(
    parameter int IMG_W        = 8,
    parameter int IMG_H        = 8,
    parameter int WIN          = 3,
    parameter int INIT_DLY     = 53,
    parameter int ROW_GAP      = 2,
    parameter int FRAME_GAP    = 20,
    parameter int AUTO_RESTART = 1,
    parameter int CNT_W        = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    median_window_scan_ctrl_if.slave   bus
);
    localparam int OUT_W = IMG_W - WIN + 1;
    localparam int OUT_H = IMG_H - WIN + 1;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int MAXD  = (INIT_DLY > ROW_GAP)
                         ? ((INIT_DLY > FRAME_GAP) ? INIT_DLY : FRAME_GAP)
                         : ((ROW_GAP > FRAME_GAP) ? ROW_GAP : FRAME_GAP);
    localparam int DW    = $clog2(MAXD + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT_WAIT = 3'd1,
        S_SCAN      = 3'd2,
        S_ROW_GAP   = 3'd3,
        S_FRAME_GAP = 3'd4
    } state_t;

    state_t           r_state, w_nxt_state;
    logic [CW-1:0]    r_col, w_nxt_col;
    logic [RW-1:0]    r_row, w_nxt_row;
    logic [DW-1:0]    r_dly, w_nxt_dly;
    logic [CNT_W-1:0] r_fcnt, w_nxt_fcnt;

    logic w_enable, w_last_col, w_last_row, w_row_end, w_frame_end;

    // Stall gates the strobe combinationally so the datapath sees it in the same cycle.
    assign w_enable    = (r_state == S_SCAN) && !bus.i_stall;
    assign w_last_col  = (r_col == CW'(OUT_W - 1));
    assign w_last_row  = (r_row == RW'(OUT_H - 1));
    assign w_row_end   = w_enable && w_last_col;
    assign w_frame_end = w_row_end && w_last_row;

    assign bus.o_state      = r_state;
    assign bus.o_enable_win = w_enable;
    assign bus.o_col        = r_col;
    assign bus.o_row        = r_row;
    assign bus.o_first_col  = w_enable && (r_col == '0);
    assign bus.o_row_end    = w_row_end;
    assign bus.o_frame_end  = w_frame_end;
    assign bus.o_busy       = (r_state != S_IDLE);
    assign bus.o_frame_cnt  = r_fcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_dly   <= '0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_col   <= w_nxt_col;
            r_row   <= w_nxt_row;
            r_dly   <= w_nxt_dly;
            r_fcnt  <= w_nxt_fcnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_col   = r_col;
        w_nxt_row   = r_row;
        w_nxt_dly   = r_dly;
        w_nxt_fcnt  = r_fcnt;

        // A frame that completes in the same cycle as an abort still counts.
        if (w_frame_end) begin
            w_nxt_fcnt = r_fcnt + CNT_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_nxt_state = S_INIT_WAIT;
                    w_nxt_dly   = DW'(INIT_DLY - 1);
                end
            end
            S_INIT_WAIT, S_ROW_GAP: begin
                if (r_dly == '0) begin
                    w_nxt_state = S_SCAN;
                end else begin
                    w_nxt_dly = r_dly - DW'(1);
                end
            end
            S_SCAN: begin
                if (w_enable) begin
                    if (!w_last_col) begin
                        w_nxt_col = r_col + CW'(1);
                    end else if (!w_last_row) begin
                        w_nxt_col   = '0;
                        w_nxt_row   = r_row + RW'(1);
                        w_nxt_state = S_ROW_GAP;
                        w_nxt_dly   = DW'(ROW_GAP - 1);
                    end else begin
                        w_nxt_col   = '0;
                        w_nxt_row   = '0;
                        w_nxt_state = S_FRAME_GAP;
                        w_nxt_dly   = DW'(FRAME_GAP - 1);
                    end
                end
            end
            S_FRAME_GAP: begin
                if (r_dly == '0) begin
                    w_nxt_state = (AUTO_RESTART != 0) ? S_SCAN : S_IDLE;
                end else begin
                    w_nxt_dly = r_dly - DW'(1);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        if (bus.i_stop) begin
            w_nxt_state = S_IDLE;
            w_nxt_col   = '0;
            w_nxt_row   = '0;
            w_nxt_dly   = '0;
        end
    end
endmodule

// File: tb/tb_median_window_scan_ctrl.sv
// tb/tb_median_window_scan_ctrl.sv - self-checking bench for median_window_scan_ctrl
module tb_median_window_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    median_window_scan_ctrl_if #(.CW(3), .RW(3), .CNT_W(8)) ifa ();
    median_window_scan_ctrl_if #(.CW(2), .RW(2), .CNT_W(8)) ifb ();

    median_window_scan_ctrl dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa)
    );

    median_window_scan_ctrl #(.WIN(5), .AUTO_RESTART(0)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb)
    );

    typedef struct {
        int run; int cyc; int st; int en; int col; int row;
        int fc;  int re;  int fe; int cnt;
    } vec_t;
    vec_t vt[$];

    task automatic add_vec(input int run, input int c, input int st, input int en,
                           input int col, input int row, input int fc, input int re,
                           input int fe, input int cnt);
        vec_t v;
        v.run = run; v.cyc = c; v.st = st; v.en = en; v.col = col; v.row = row;
        v.fc = fc; v.re = re; v.fe = fe; v.cnt = cnt;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic start_a();
        ifa.i_start = 1'b1;
        cyc = 0;
        tick();
        ifa.i_start = 1'b0;
    endtask

    int en_cnt, fc_cnt, fe_cnt, fe_cyc, max_col, max_row;

    initial begin
        ifa.i_start = 0; ifa.i_stop = 0; ifa.i_stall = 0;
        ifb.i_start = 0; ifb.i_stop = 0; ifb.i_stall = 0;

        // run, cyc, state, en, col, row, first_col, row_end, frame_end, frame_cnt
        add_vec(0,   1, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0,  53, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0,  54, 2, 1, 0, 0, 1, 0, 0, 0);
        add_vec(0,  59, 2, 1, 5, 0, 0, 1, 0, 0);
        add_vec(0,  60, 3, 0, 0, 1, 0, 0, 0, 0);
        add_vec(0,  61, 3, 0, 0, 1, 0, 0, 0, 0);
        add_vec(0,  62, 2, 1, 0, 1, 1, 0, 0, 0);
        add_vec(0,  94, 2, 1, 0, 5, 1, 0, 0, 0);
        add_vec(0,  99, 2, 1, 5, 5, 0, 1, 1, 0);
        add_vec(0, 100, 4, 0, 0, 0, 0, 0, 0, 1);
        add_vec(0, 119, 4, 0, 0, 0, 0, 0, 0, 1);
        add_vec(0, 120, 2, 1, 0, 0, 1, 0, 0, 1);
        add_vec(1,  55, 2, 1, 1, 0, 0, 0, 0, 0);
        add_vec(1,  56, 2, 0, 2, 0, 0, 0, 0, 0);
        add_vec(1,  58, 2, 0, 2, 0, 0, 0, 0, 0);
        add_vec(1,  59, 2, 1, 2, 0, 0, 0, 0, 0);
        add_vec(1,  62, 2, 1, 5, 0, 0, 1, 0, 0);
        add_vec(1,  63, 3, 0, 0, 1, 0, 0, 0, 0);
        add_vec(1, 102, 2, 1, 5, 5, 0, 1, 1, 0);
        add_vec(1, 103, 4, 0, 0, 0, 0, 0, 0, 1);
        add_vec(1, 123, 2, 1, 0, 0, 1, 0, 0, 1);

        // Reset state, with stall high to confirm the strobe stays low in IDLE.
        ifa.i_stall = 1'b1;
        #2;
        chk("rst_state", ifa.o_state, 0);
        chk("rst_en",    ifa.o_enable_win, 0);
        chk("rst_col",   ifa.o_col, 0);
        chk("rst_row",   ifa.o_row, 0);
        chk("rst_busy",  ifa.o_busy, 0);
        chk("rst_fcnt",  ifa.o_frame_cnt, 0);
        chk("rst_fend",  ifa.o_frame_end, 0);
        ifa.i_stall = 1'b0;

        // Run 0: plain frame; run 1: 3-cycle stall at col 2.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            start_a();
            en_cnt = 0; fc_cnt = 0; fe_cnt = 0; fe_cyc = -1;
            while (cyc <= 125) begin
                ifa.i_stall = (r == 1 && cyc >= 56 && cyc <= 58);
                #1;
                if (cyc <= 119 + 3 * r) begin
                    if (ifa.o_enable_win) en_cnt++;
                    if (ifa.o_first_col)  fc_cnt++;
                    if (ifa.o_frame_end) begin
                        fe_cnt++;
                        if (fe_cyc < 0) fe_cyc = cyc;
                    end
                end
                foreach (vt[i]) begin
                    if (vt[i].run == r && vt[i].cyc == cyc) begin
                        chk($sformatf("r%0d_c%0d_state", r, cyc), ifa.o_state, vt[i].st);
                        chk($sformatf("r%0d_c%0d_en",    r, cyc), ifa.o_enable_win, vt[i].en);
                        chk($sformatf("r%0d_c%0d_col",   r, cyc), ifa.o_col, vt[i].col);
                        chk($sformatf("r%0d_c%0d_row",   r, cyc), ifa.o_row, vt[i].row);
                        chk($sformatf("r%0d_c%0d_first", r, cyc), ifa.o_first_col, vt[i].fc);
                        chk($sformatf("r%0d_c%0d_rend",  r, cyc), ifa.o_row_end, vt[i].re);
                        chk($sformatf("r%0d_c%0d_fend",  r, cyc), ifa.o_frame_end, vt[i].fe);
                        chk($sformatf("r%0d_c%0d_fcnt",  r, cyc), ifa.o_frame_cnt, vt[i].cnt);
                        chk($sformatf("r%0d_c%0d_busy",  r, cyc), ifa.o_busy, (vt[i].st != 0) ? 1 : 0);
                    end
                end
                tick();
            end
            ifa.i_stall = 1'b0;
            chk($sformatf("r%0d_enables", r), en_cnt, 36);
            chk($sformatf("r%0d_first_cols", r), fc_cnt, 6);
            chk($sformatf("r%0d_frame_ends", r), fe_cnt, 1);
            chk($sformatf("r%0d_frame_end_cyc", r), fe_cyc, (r == 0) ? 99 : 102);
        end

        // Abort mid-SCAN at cycle 70.
        do_reset();
        start_a();
        run_to(70);
        ifa.i_stop = 1'b1;
        #1;
        chk("stop_pre_state", ifa.o_state, 2);
        tick();
        ifa.i_stop = 1'b0;
        #1;
        chk("stop_state", ifa.o_state, 0);
        chk("stop_col",   ifa.o_col, 0);
        chk("stop_row",   ifa.o_row, 0);
        chk("stop_busy",  ifa.o_busy, 0);
        chk("stop_fcnt",  ifa.o_frame_cnt, 0);
        // Stop has priority over start in IDLE.
        ifa.i_stop = 1'b1; ifa.i_start = 1'b1;
        tick();
        ifa.i_stop = 1'b0; ifa.i_start = 1'b0;
        #1;
        chk("stop_start_state", ifa.o_state, 0);
        tick();
        chk("stop_start_state2", ifa.o_state, 0);

        // Abort coinciding with the last window: frame still counts.
        do_reset();
        start_a();
        run_to(99);
        ifa.i_stop = 1'b1;
        #1;
        chk("stopfe_fend", ifa.o_frame_end, 1);
        tick();
        ifa.i_stop = 1'b0;
        #1;
        chk("stopfe_state", ifa.o_state, 0);
        chk("stopfe_fcnt",  ifa.o_frame_cnt, 1);

        // Asynchronous reset during FRAME_GAP of the second frame.
        do_reset();
        start_a();
        run_to(166);
        #1;
        chk("arst_pre_state", ifa.o_state, 4);
        chk("arst_pre_fcnt",  ifa.o_frame_cnt, 2);
        rst = 1'b1;
        #1;
        chk("arst_state", ifa.o_state, 0);
        chk("arst_fcnt",  ifa.o_frame_cnt, 0);
        chk("arst_busy",  ifa.o_busy, 0);
        chk("arst_col",   ifa.o_col, 0);
        chk("arst_row",   ifa.o_row, 0);
        #2;
        rst = 1'b0;
        en_cnt = 0; fc_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (ifa.o_enable_win) en_cnt++;
            if (ifa.o_busy) fc_cnt++;
        end
        chk("arst_no_enables", en_cnt, 0);
        chk("arst_no_busy",    fc_cnt, 0);

        // WIN=5, AUTO_RESTART=0 instance.
        do_reset();
        ifb.i_start = 1'b1;
        cyc = 0;
        tick();
        ifb.i_start = 1'b0;
        en_cnt = 0; fe_cyc = -1; max_col = 0; max_row = 0;
        while (cyc <= 100) begin
            ifb.i_start = (cyc == 60 || cyc == 100);
            #1;
            if (ifb.o_enable_win) begin
                en_cnt++;
                if (int'(ifb.o_col) > max_col) max_col = int'(ifb.o_col);
                if (int'(ifb.o_row) > max_row) max_row = int'(ifb.o_row);
            end
            if (ifb.o_frame_end && fe_cyc < 0) fe_cyc = cyc;
            if (cyc == 61) begin
                chk("b_c61_state", ifb.o_state, 2);
                chk("b_c61_col",   ifb.o_col, 1);
            end
            if (cyc == 95) chk("b_c95_state", ifb.o_state, 4);
            if (cyc == 96) begin
                chk("b_c96_state", ifb.o_state, 0);
                chk("b_c96_busy",  ifb.o_busy, 0);
                chk("b_c96_fcnt",  ifb.o_frame_cnt, 1);
            end
            tick();
        end
        ifb.i_start = 1'b0;
        #1;
        chk("b_enables",   en_cnt, 16);
        chk("b_max_col",   max_col, 3);
        chk("b_max_row",   max_row, 3);
        chk("b_fend_cyc",  fe_cyc, 75);
        chk("b_c101_state", ifb.o_state, 1);
        chk("b_c101_fcnt",  ifb.o_frame_cnt, 1);
        run_to(153);
        chk("b_c153_state", ifb.o_state, 1);
        tick();
        chk("b_c154_state", ifb.o_state, 2);
        chk("b_c154_en",    ifb.o_enable_win, 1);
        chk("b_c154_col",   ifb.o_col, 0);
        chk("b_c154_row",   ifb.o_row, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
